// File: rtl/bsg_mesh_router_pkg.sv
// Shared types for the mesh/ruche wormhole routing decoder: direction indices,
// header layout macro and the decoder state encoding.
`ifndef BSG_MESH_ROUTER_PKG_SV
`define BSG_MESH_ROUTER_PKG_SV

// Header flit layout, LSB-first {x, y, len}; packed fields are listed MSB-first.
`define BSG_MESH_ROUTER_HDR_T(name, x_w, y_w, len_w) \
    typedef struct packed { \
        logic [(len_w)-1:0] len; \
        logic [(y_w)-1:0]   y; \
        logic [(x_w)-1:0]   x; \
    } name;

package bsg_mesh_router_pkg;

    typedef enum logic [3:0] {
        e_dir_p  = 4'd0,
        e_dir_w  = 4'd1,
        e_dir_e  = 4'd2,
        e_dir_n  = 4'd3,
        e_dir_s  = 4'd4,
        e_dir_rw = 4'd5,
        e_dir_re = 4'd6,
        e_dir_rn = 4'd7,
        e_dir_rs = 4'd8
    } dir_e;

    typedef enum logic {
        e_head,
        e_body
    } state_e;

    localparam int max_dirs_lp = 9;

endpackage

`endif

// File: rtl/bsg_mesh_route_compute.sv
// Combinational dimension-ordered route decode (XY or YX) with optional ruche
// express links; YX mode uses the depopulated ruche keyed on the input direction.
module bsg_mesh_route_compute
    import bsg_mesh_router_pkg::*;
#(
    parameter int x_cord_width_p   = 4,
    parameter int y_cord_width_p   = 4,
    parameter int dims_p           = 2,
    parameter int ruche_factor_X_p = 0,
    parameter int ruche_factor_Y_p = 0,
    parameter int from_dir_p       = 0,
    localparam int dirs_lp         = 2*dims_p+1
) (
    input  logic [x_cord_width_p-1:0] dest_x_i,
    input  logic [y_cord_width_p-1:0] dest_y_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic                      xy_order_i,
    output logic [dirs_lp-1:0]        route_o
);

    localparam logic [max_dirs_lp-1:0] from_oh_lp = max_dirs_lp'(1) << from_dir_p;
    localparam bit ruche_x_lp = (ruche_factor_X_p != 0);
    localparam bit ruche_y_lp = (ruche_factor_Y_p != 0);
    localparam int rfx_mod_lp = ruche_x_lp ? ruche_factor_X_p : 1;
    localparam int rfy_mod_lp = ruche_y_lp ? ruche_factor_Y_p : 1;

    logic x_eq, x_gt, x_lt, y_eq, y_gt, y_lt;
    logic [x_cord_width_p:0]   x_ahead;
    logic [y_cord_width_p:0]   y_ahead;
    logic [x_cord_width_p-1:0] x_back, dx;
    logic [y_cord_width_p-1:0] y_back, dy;
    logic send_re, send_rw, send_rs, send_rn, dx_hit, dy_hit;
    logic [max_dirs_lp-1:0] route_full;

    assign x_eq = (dest_x_i == my_x_i);
    assign x_gt = (dest_x_i >  my_x_i);
    assign x_lt = (dest_x_i <  my_x_i);
    assign y_eq = (dest_y_i == my_y_i);
    assign y_gt = (dest_y_i >  my_y_i);
    assign y_lt = (dest_y_i <  my_y_i);

    // Carry bit of the widened sum flags a ruche target beyond the coordinate range.
    assign x_ahead = {1'b0, my_x_i} + (x_cord_width_p+1)'(ruche_factor_X_p);
    assign y_ahead = {1'b0, my_y_i} + (y_cord_width_p+1)'(ruche_factor_Y_p);
    assign x_back  = my_x_i - x_cord_width_p'(ruche_factor_X_p);
    assign y_back  = my_y_i - y_cord_width_p'(ruche_factor_Y_p);

    assign send_re = ruche_x_lp & ~x_ahead[x_cord_width_p]
                   & (dest_x_i > x_ahead[x_cord_width_p-1:0]);
    assign send_rw = ruche_x_lp & (my_x_i > x_cord_width_p'(ruche_factor_X_p))
                   & (dest_x_i < x_back);
    assign send_rs = ruche_y_lp & ~y_ahead[y_cord_width_p]
                   & (dest_y_i > y_ahead[y_cord_width_p-1:0]);
    assign send_rn = ruche_y_lp & (my_y_i > y_cord_width_p'(ruche_factor_Y_p))
                   & (dest_y_i < y_back);

    assign dx     = x_gt ? (dest_x_i - my_x_i) : (my_x_i - dest_x_i);
    assign dy     = y_gt ? (dest_y_i - my_y_i) : (my_y_i - dest_y_i);
    assign dx_hit = ruche_x_lp & ((dx % x_cord_width_p'(rfx_mod_lp)) == '0);
    assign dy_hit = ruche_y_lp & ((dy % y_cord_width_p'(rfy_mod_lp)) == '0);

    always_comb begin
        route_full          = '0;
        route_full[e_dir_p] = x_eq & y_eq;
        if (xy_order_i) begin
            route_full[e_dir_w]  = x_lt & ~send_rw;
            route_full[e_dir_e]  = x_gt & ~send_re;
            route_full[e_dir_rw] = send_rw;
            route_full[e_dir_re] = send_re;
            route_full[e_dir_n]  = x_eq & y_lt & ~send_rn;
            route_full[e_dir_s]  = x_eq & y_gt & ~send_rs;
            route_full[e_dir_rn] = x_eq & send_rn;
            route_full[e_dir_rs] = x_eq & send_rs;
        end else begin
            // Y first: straight or ruche continuation depends on where the packet came from.
            if (from_oh_lp[e_dir_n]) begin
                route_full[e_dir_rs] = y_gt & dy_hit;
                route_full[e_dir_s]  = y_gt & ~dy_hit;
            end else if (from_oh_lp[e_dir_s]) begin
                route_full[e_dir_rn] = y_lt & dy_hit;
                route_full[e_dir_n]  = y_lt & ~dy_hit;
            end else if (from_oh_lp[e_dir_rn]) begin
                route_full[e_dir_rs] = y_gt;
            end else if (from_oh_lp[e_dir_rs]) begin
                route_full[e_dir_rn] = y_lt;
            end else begin
                route_full[e_dir_n]  = y_lt;
                route_full[e_dir_s]  = y_gt;
            end

            if (from_oh_lp[e_dir_w]) begin
                route_full[e_dir_re] = y_eq & x_gt & dx_hit;
                route_full[e_dir_e]  = y_eq & x_gt & ~dx_hit;
            end else if (from_oh_lp[e_dir_e]) begin
                route_full[e_dir_rw] = y_eq & x_lt & dx_hit;
                route_full[e_dir_w]  = y_eq & x_lt & ~dx_hit;
            end else if (from_oh_lp[e_dir_rw]) begin
                route_full[e_dir_re] = y_eq & x_gt;
            end else if (from_oh_lp[e_dir_re]) begin
                route_full[e_dir_rw] = y_eq & x_lt;
            end else begin
                route_full[e_dir_e]  = y_eq & x_gt;
                route_full[e_dir_w]  = y_eq & x_lt;
            end
        end
    end

    assign route_o = route_full[dirs_lp-1:0];

`ifndef SYNTHESIS
    // Directions beyond dirs_lp must never be selected by a valid configuration.
    always_comb assert ((route_full >> dirs_lp) == '0);
`endif

endmodule

// File: rtl/bsg_mesh_router_decoder_wormhole.sv
// Per-input wormhole routing decoder: decodes the header, locks the route until the tail.
// Optional completed-packet counter enabled by BSG_MESH_DECODER_PKT_CNT_EN.
module bsg_mesh_router_decoder_wormhole
    import bsg_mesh_router_pkg::*;
#(
    parameter int x_cord_width_p   = 4,
    parameter int y_cord_width_p   = 4,
    parameter int len_width_p      = 4,
    parameter int flit_width_p     = 32,
    parameter int dims_p           = 2,
    parameter int ruche_factor_X_p = 0,
    parameter int ruche_factor_Y_p = 0,
    parameter int from_dir_p       = 0,
    localparam int dirs_lp         = 2*dims_p+1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    input  logic [flit_width_p-1:0]   data_i,
    input  logic                      yumi_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic                      xy_order_i,
    output logic [dirs_lp-1:0]        req_o,
    output logic                      tail_o,
    output logic [31:0]               pkt_cnt_o
);

    `BSG_MESH_ROUTER_HDR_T(hdr_s, x_cord_width_p, y_cord_width_p, len_width_p)
    localparam int hdr_width_lp = $bits(hdr_s);

    hdr_s                   hdr;
    state_e                 state_r, state_n;
    logic [len_width_p-1:0] count_r, count_n;
    logic [dirs_lp-1:0]     route_r, route_n, route_comb;
    logic                   pkt_done;

    assign hdr = data_i[hdr_width_lp-1:0];

    bsg_mesh_route_compute #(
        .x_cord_width_p  (x_cord_width_p),
        .y_cord_width_p  (y_cord_width_p),
        .dims_p          (dims_p),
        .ruche_factor_X_p(ruche_factor_X_p),
        .ruche_factor_Y_p(ruche_factor_Y_p),
        .from_dir_p      (from_dir_p)
    ) route_compute (
        .dest_x_i  (hdr.x),
        .dest_y_i  (hdr.y),
        .my_x_i    (my_x_i),
        .my_y_i    (my_y_i),
        .xy_order_i(xy_order_i),
        .route_o   (route_comb)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_head;
            count_r <= '0;
            route_r <= '0;
        end else begin
            state_r <= state_n;
            count_r <= count_n;
            route_r <= route_n;
        end
    end

    always_comb begin
        state_n  = state_r;
        count_n  = count_r;
        route_n  = route_r;
        pkt_done = 1'b0;
        req_o    = '0;
        tail_o   = 1'b0;
        unique case (state_r)
            e_head: begin
                req_o  = {dirs_lp{v_i}} & route_comb;
                tail_o = v_i & (hdr.len == '0);
                if (yumi_i) begin
                    if (hdr.len != '0) begin
                        route_n = route_comb;
                        count_n = hdr.len;
                        state_n = e_body;
                    end else begin
                        pkt_done = 1'b1;
                    end
                end
            end
            e_body: begin
                req_o  = {dirs_lp{v_i}} & route_r;
                tail_o = v_i & (count_r == len_width_p'(1));
                if (yumi_i) begin
                    count_n = count_r - len_width_p'(1);
                    if (count_r == len_width_p'(1)) begin
                        state_n  = e_head;
                        pkt_done = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef BSG_MESH_DECODER_PKT_CNT_EN
    logic [31:0] pkt_cnt_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pkt_cnt_r <= '0;
        end else if (pkt_done) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
        end
    end

    assign pkt_cnt_o = pkt_cnt_r;
`else
    assign pkt_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !v_i));
            assert ($countones(req_o) <= 1);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_mesh_router_decoder_wormhole.sv
// Directed bench: XY decoder (dims 3, ruche X 3, from P) and YX decoder (dims 4, ruche X 2, from W).
module tb_bsg_mesh_router_decoder_wormhole;

`ifdef BSG_MESH_DECODER_PKT_CNT_EN
    localparam bit cnt_en = 1'b1;
`else
    localparam bit cnt_en = 1'b0;
`endif

    logic        clk, rst_n;
    logic        v_a, yumi_a, xy_a, tail_a;
    logic [31:0] data_a, cnt_a;
    logic [6:0]  req_a;
    logic        v_b, yumi_b, xy_b, tail_b;
    logic [31:0] data_b, cnt_b;
    logic [8:0]  req_b;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned exp_cnt_a   = 0;

    bsg_mesh_router_decoder_wormhole #(
        .x_cord_width_p(4), .y_cord_width_p(4), .len_width_p(4), .flit_width_p(32),
        .dims_p(3), .ruche_factor_X_p(3), .ruche_factor_Y_p(0), .from_dir_p(0)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_a), .data_i(data_a), .yumi_i(yumi_a),
        .my_x_i(4'd4), .my_y_i(4'd2), .xy_order_i(xy_a),
        .req_o(req_a), .tail_o(tail_a), .pkt_cnt_o(cnt_a)
    );

    bsg_mesh_router_decoder_wormhole #(
        .x_cord_width_p(4), .y_cord_width_p(4), .len_width_p(4), .flit_width_p(32),
        .dims_p(4), .ruche_factor_X_p(2), .ruche_factor_Y_p(0), .from_dir_p(1)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_b), .data_i(data_b), .yumi_i(yumi_b),
        .my_x_i(4'd1), .my_y_i(4'd1), .xy_order_i(xy_b),
        .req_o(req_b), .tail_o(tail_b), .pkt_cnt_o(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] hdr(int unsigned x, int unsigned y, int unsigned len);
        return 32'((len << 8) | (y << 4) | x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        vectors += 4;
        if (req_a !== 7'd0) begin miscompares++; $display("FAIL reset_req_a got %0h want 0", req_a); end
        if (tail_a !== 1'b0) begin miscompares++; $display("FAIL reset_tail_a got %0b want 0", tail_a); end
        if (cnt_a !== 32'd0) begin miscompares++; $display("FAIL reset_cnt_a got %0d want 0", cnt_a); end
        if (req_b !== 9'd0) begin miscompares++; $display("FAIL reset_req_b got %0h want 0", req_b); end
        rst_n = 1'b1;
        tick();
        // Header len=3 to E, then abort with reset while the packet is in BODY.
        v_a = 1'b1; data_a = hdr(6, 2, 3); yumi_a = 1'b1; xy_a = 1'b1;
        #1;
        vectors++;
        if (req_a !== 7'h04) begin miscompares++; $display("FAIL abort_hdr got %0h want 04", req_a); end
        tick();
        data_a = hdr(2, 2, 0); yumi_a = 1'b0;
        #1;
        vectors++;
        if (req_a !== 7'h04) begin miscompares++; $display("FAIL abort_locked got %0h want 04", req_a); end
        rst_n = 1'b0;
        #1;
        vectors += 2;
        if (req_a !== 7'h02) begin miscompares++; $display("FAIL abort_fresh got %0h want 02", req_a); end
        if (tail_a !== 1'b1) begin miscompares++; $display("FAIL abort_tail got %0b want 1", tail_a); end
        v_a = 1'b0;
        #1;
        vectors++;
        if (req_a !== 7'd0) begin miscompares++; $display("FAIL abort_idle got %0h want 0", req_a); end
        tick();
        rst_n = 1'b1;
        tick();
        v_a = 1'b1; data_a = hdr(2, 2, 0); yumi_a = 1'b1;
        #1;
        vectors++;
        if (req_a !== 7'h02) begin miscompares++; $display("FAIL post_reset_hdr got %0h want 02", req_a); end
        tick();
        v_a = 1'b0; yumi_a = 1'b0;
        exp_cnt_a++;
        #1;
        vectors++;
        if (cnt_a !== (cnt_en ? 32'(exp_cnt_a) : 32'd0)) begin
            miscompares++; $display("FAIL post_reset_cnt got %0d want %0d", cnt_a, cnt_en ? exp_cnt_a : 0);
        end
    endtask

    task automatic test_xy_decode();
        int       tx  [7] = '{9, 6, 4, 4, 0, 2, 7};
        int       ty  [7] = '{2, 2, 2, 5, 2, 2, 2};
        int       exp [7] = '{'h40, 'h04, 'h01, 'h10, 'h20, 'h02, 'h04};
        xy_a = 1'b1; yumi_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            v_a = 1'b1; data_a = hdr(tx[i], ty[i], 0);
            #1;
            vectors += 2;
            if (req_a !== 7'(exp[i])) begin
                miscompares++; $display("FAIL xy_dest(%0d,%0d) got %0h want %0h", tx[i], ty[i], req_a, exp[i]);
            end
            if (tail_a !== 1'b1) begin miscompares++; $display("FAIL xy_tail%0d got %0b want 1", i, tail_a); end
        end
        v_a = 1'b0;
    endtask

    task automatic test_wormhole();
        tick();
        v_a = 1'b1; data_a = hdr(6, 2, 2); yumi_a = 1'b1; xy_a = 1'b1;
        #1;
        vectors += 2;
        if (req_a !== 7'h04) begin miscompares++; $display("FAIL worm_hdr got %0h want 04", req_a); end
        if (tail_a !== 1'b0) begin miscompares++; $display("FAIL worm_hdr_tail got %0b want 0", tail_a); end
        tick();
        data_a = hdr(2, 2, 0);
        #1;
        vectors += 2;
        if (req_a !== 7'h04) begin miscompares++; $display("FAIL worm_body1 got %0h want 04", req_a); end
        if (tail_a !== 1'b0) begin miscompares++; $display("FAIL worm_body1_tail got %0b want 0", tail_a); end
        tick();
        v_a = 1'b0; yumi_a = 1'b0;
        #1;
        vectors++;
        if (req_a !== 7'd0) begin miscompares++; $display("FAIL worm_gap got %0h want 0", req_a); end
        tick();
        v_a = 1'b1; yumi_a = 1'b1;
        #1;
        vectors += 2;
        if (req_a !== 7'h04) begin miscompares++; $display("FAIL worm_body2 got %0h want 04", req_a); end
        if (tail_a !== 1'b1) begin miscompares++; $display("FAIL worm_body2_tail got %0b want 1", tail_a); end
        tick();
        exp_cnt_a++;
        yumi_a = 1'b0;
        #1;
        vectors += 2;
        if (req_a !== 7'h02) begin miscompares++; $display("FAIL worm_next_hdr got %0h want 02", req_a); end
        if (cnt_a !== (cnt_en ? 32'(exp_cnt_a) : 32'd0)) begin
            miscompares++; $display("FAIL worm_cnt got %0d want %0d", cnt_a, cnt_en ? exp_cnt_a : 0);
        end
        v_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        tick();
        xy_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v_a = 1'b1; yumi_a = 1'b1;
            data_a = (i % 2 == 0) ? hdr(4, 0, 0) : hdr(4, 5, 0);
            #1;
            vectors += 2;
            if (req_a !== ((i % 2 == 0) ? 7'h08 : 7'h10)) begin
                miscompares++; $display("FAIL b2b_req%0d got %0h want %0h", i, req_a, (i % 2 == 0) ? 8 : 16);
            end
            if (tail_a !== 1'b1) begin miscompares++; $display("FAIL b2b_tail%0d got %0b want 1", i, tail_a); end
            tick();
            exp_cnt_a++;
        end
        v_a = 1'b0; yumi_a = 1'b0;
        #1;
        vectors++;
        if (cnt_a !== (cnt_en ? 32'(exp_cnt_a) : 32'd0)) begin
            miscompares++; $display("FAIL b2b_cnt got %0d want %0d", cnt_a, cnt_en ? exp_cnt_a : 0);
        end
    endtask

    task automatic test_yx_ruche();
        int       tx  [7] = '{5, 4, 4, 3, 1, 0, 1};
        int       ty  [7] = '{1, 1, 3, 1, 1, 1, 0};
        int       exp [7] = '{'h040, 'h004, 'h010, 'h040, 'h001, 'h000, 'h008};
        xy_b = 1'b0; yumi_b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            v_b = 1'b1; data_b = hdr(tx[i], ty[i], 0);
            #1;
            vectors++;
            if (req_b !== 9'(exp[i])) begin
                miscompares++; $display("FAIL yx_dest(%0d,%0d) got %0h want %0h", tx[i], ty[i], req_b, exp[i]);
            end
        end
        v_b = 1'b0;
        #1;
        vectors++;
        if (cnt_b !== 32'd0) begin miscompares++; $display("FAIL yx_cnt got %0d want 0", cnt_b); end
    endtask

    task automatic test_mode_change();
        tick();
        v_a = 1'b1; data_a = hdr(6, 5, 1); yumi_a = 1'b1; xy_a = 1'b1;
        #1;
        vectors++;
        if (req_a !== 7'h04) begin miscompares++; $display("FAIL mode_hdr got %0h want 04", req_a); end
        tick();
        xy_a = 1'b0; data_a = hdr(6, 5, 0); yumi_a = 1'b0;
        #1;
        vectors += 2;
        if (req_a !== 7'h04) begin miscompares++; $display("FAIL mode_locked got %0h want 04", req_a); end
        if (tail_a !== 1'b1) begin miscompares++; $display("FAIL mode_tail got %0b want 1", tail_a); end
        tick();
        vectors++;
        if (req_a !== 7'h04) begin miscompares++; $display("FAIL mode_hold got %0h want 04", req_a); end
        yumi_a = 1'b1;
        tick();
        exp_cnt_a++;
        yumi_a = 1'b0;
        #1;
        vectors++;
        if (req_a !== 7'h10) begin miscompares++; $display("FAIL mode_yx_hdr got %0h want 10", req_a); end
        xy_a = 1'b1;
        #1;
        vectors += 2;
        if (req_a !== 7'h04) begin miscompares++; $display("FAIL mode_xy_hdr got %0h want 04", req_a); end
        if (cnt_a !== (cnt_en ? 32'(exp_cnt_a) : 32'd0)) begin
            miscompares++; $display("FAIL mode_cnt got %0d want %0d", cnt_a, cnt_en ? exp_cnt_a : 0);
        end
        v_a = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        v_a = 1'b0; yumi_a = 1'b0; xy_a = 1'b1; data_a = '0;
        v_b = 1'b0; yumi_b = 1'b0; xy_b = 1'b0; data_b = '0;
        test_reset();
        test_xy_decode();
        test_wormhole();
        test_back_to_back();
        test_yx_ruche();
        test_mode_change();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
